// File: rtl/rgb_gray_reader_if.sv
// rgb_gray_reader_if: frame-buffer byte stream,
// luma output handshake and controller signals.
interface rgb_gray_reader_if;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       pause;
  logic [7:0] gray_data;
  logic       gray_valid;
  logic       gray_ready;
  logic       done;
  logic       overrun;

  modport master (
    output start,
    output in_valid,
    output in_data,
    output gray_ready,
    input  pause,
    input  gray_data,
    input  gray_valid,
    input  done,
    input  overrun
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_data,
    input  gray_ready,
    output pause,
    output gray_data,
    output gray_valid,
    output done,
    output overrun
  );
endinterface

// File: rtl/rgb_gray_reader.sv
// rgb_gray_reader: R,G,B byte stream to 8-bit
// luma, one-byte skid absorbs bytes sent while paused.
module rgb_gray_reader #(
  parameter int N = 480,
  parameter int M = 320
) (
  input  logic clk,
  input  logic rst,
  rgb_gray_reader_if.slave bus
);

  localparam int PIX = N * M;
  localparam int CW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(PIX - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CALC,
    OUT
  } state_t;

  state_t        state;
  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [7:0]    b_q;
  logic [7:0]    skid_q;
  logic          skid_full;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [7:0]    gray_q;
  logic          gv_q;
  logic          done_q;
  logic          ovr_q;

  logic          take;
  logic [7:0]    take_byte;
  logic [15:0]   acc;
  logic          pause_c;

  // Byte selection: skid has priority over the live stream
  always_comb begin
    take      = 1'b0;
    take_byte = bus.in_data;
    if (state == COLLECT) begin
      take      = skid_full | bus.in_valid;
      take_byte = skid_full ? skid_q : bus.in_data;
    end
  end

  // Luma: weights sum to 256, +128 rounds, fits 16 bits
  always_comb begin
    acc = 16'd77  * {8'd0, r_q}
        + 16'd150 * {8'd0, g_q}
        + 16'd29  * {8'd0, b_q}
        + 16'd128;
  end

  // Hold the read address whenever a byte cannot be taken
  always_comb begin
    pause_c = 1'b0;
    unique case (state)
      CALC:    pause_c = 1'b1;
      OUT:     pause_c = 1'b1;
      COLLECT: pause_c = skid_full;
      default: pause_c = 1'b0;
    endcase
  end

  assign bus.pause      = pause_c;
  assign bus.gray_data  = gray_q;
  assign bus.gray_valid = gv_q;
  assign bus.done       = done_q;
  assign bus.overrun    = ovr_q;

  // Frame FSM, skid buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      skid_q    <= '0;
      skid_full <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      gray_q    <= '0;
      gv_q      <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= COLLECT;
            cnt       <= '0;
            idx       <= '0;
            skid_full <= 1'b0;
            ovr_q     <= 1'b0;
          end
        end
        COLLECT: begin
          if (take) begin
            unique case (idx)
              2'd0:    r_q <= take_byte;
              2'd1:    g_q <= take_byte;
              default: b_q <= take_byte;
            endcase
            if (idx == 2'd2) begin
              idx   <= '0;
              state <= CALC;
            end else begin
              idx <= idx + 2'd1;
            end
          end
          if (skid_full) begin
            if (bus.in_valid) begin
              skid_q <= bus.in_data;
            end else begin
              skid_full <= 1'b0;
            end
          end
        end
        CALC: begin
          gray_q <= acc[15:8];
          gv_q   <= 1'b1;
          state  <= OUT;
          if (bus.in_valid) begin
            if (!skid_full) begin
              skid_q    <= bus.in_data;
              skid_full <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end
        OUT: begin
          if (bus.in_valid) begin
            if (!skid_full) begin
              skid_q    <= bus.in_data;
              skid_full <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
          if (bus.gray_ready) begin
            gv_q <= 1'b0;
            if (cnt == LAST) begin
              done_q    <= 1'b1;
              cnt       <= '0;
              idx       <= '0;
              skid_full <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= COLLECT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
